// File: rtl/systolic_result_collector_if.sv
// Handshake bundle between the systolic array byte stream, the row collector and its downstream consumer.
// slave is the collector's view; master is the view of whatever drives bytes and pops rows.
interface systolic_result_collector_if #(
  parameter int width_p        = 8,
  parameter int array_width_p  = 8,
  parameter int array_height_p = 8
);
  localparam int row_w = width_p * array_width_p;
  localparam int idx_w = (array_height_p > 1) ? $clog2(array_height_p) : 1;

  logic               v_i;
  logic [width_p-1:0] data_i;
  logic               yumi_o;
  logic               valid_o;
  logic [row_w-1:0]   data_o;
  logic [idx_w-1:0]   row_idx_o;
  logic               tile_last_o;
  logic               yumi_i;

  modport slave (
    input  v_i, data_i, yumi_i,
    output yumi_o, valid_o, data_o, row_idx_o, tile_last_o
  );

  modport master (
    output v_i, data_i, yumi_i,
    input  yumi_o, valid_o, data_o, row_idx_o, tile_last_o
  );
endinterface

// File: rtl/systolic_result_collector.sv
// Packs systolic array result bytes into tagged rows and buffers them in a small FIFO.
// Optional build macro SYSTOLIC_COLLECTOR_PERF_CNT_EN adds saturating stall/row/tile counters.
module systolic_result_collector #(
  parameter int width_p        = 8,
  parameter int array_width_p  = 8,
  parameter int array_height_p = 8,
  parameter int depth_p        = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic flush_i,
  systolic_result_collector_if.slave bus,
  output logic [$clog2(array_width_p+1)-1:0] partial_o
`ifdef SYSTOLIC_COLLECTOR_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] row_cnt_o,
  output logic [31:0] tile_cnt_o
`endif
);
  localparam int row_w  = width_p * array_width_p;
  localparam int cnt_w  = $clog2(array_width_p + 1);
  localparam int idx_w  = (array_height_p > 1) ? $clog2(array_height_p) : 1;
  localparam int ptr_w  = $clog2(depth_p);
  localparam int fcnt_w = $clog2(depth_p + 1);
  localparam logic [cnt_w-1:0]  last_lane = cnt_w'(array_width_p - 1);
  localparam logic [idx_w-1:0]  last_row  = idx_w'(array_height_p - 1);
  localparam logic [fcnt_w-1:0] full_cnt  = fcnt_w'(depth_p);

  typedef struct packed {
    logic [row_w-1:0] data;
    logic [idx_w-1:0] row_idx;
    logic             tile_last;
  } entry_t;

  logic [width_p-1:0] lane_reg [array_width_p-1];
  entry_t             mem_reg  [depth_p];
  logic [ptr_w-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [fcnt_w-1:0]  count_reg;
  logic [cnt_w-1:0]   byte_cnt_reg;
  logic [idx_w-1:0]   row_idx_reg;
  logic [row_w-1:0]   push_data;
  entry_t             head;
  logic               fifo_full, fifo_valid, last_byte;
  logic               pop, stall, accept, push;

  assign fifo_full  = (count_reg == full_cnt);
  assign fifo_valid = (count_reg != '0);
  assign last_byte  = (byte_cnt_reg == last_lane);
  assign pop        = fifo_valid & bus.yumi_i & en_i & ~flush_i & ~reset_i;
  // A pop in the same cycle frees the slot the completing row needs.
  assign stall      = last_byte & fifo_full & ~pop;
  assign accept     = bus.v_i & en_i & ~flush_i & ~reset_i & ~stall;
  assign push       = accept & last_byte;

  assign head            = mem_reg[rd_ptr_reg];
  assign bus.yumi_o      = accept;
  assign bus.valid_o     = fifo_valid;
  assign bus.data_o      = head.data;
  assign bus.row_idx_o   = head.row_idx;
  assign bus.tile_last_o = head.tile_last;
  assign partial_o       = byte_cnt_reg;

  // The final lane is never stored in the assembler; it goes straight into the FIFO word.
  generate
    for (genvar gi = 0; gi < array_width_p; gi++) begin : g_lane
      if (gi == array_width_p - 1) begin : g_direct
        assign push_data[gi*width_p +: width_p] = bus.data_i;
      end else begin : g_stored
        assign push_data[gi*width_p +: width_p] = lane_reg[gi];
        always_ff @(posedge clk_i) begin
          if (reset_i) begin
            lane_reg[gi] <= '0;
          end else if (accept && (byte_cnt_reg == cnt_w'(gi))) begin
            lane_reg[gi] <= bus.data_i;
          end
        end
      end
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < depth_p; gi++) begin : g_entry
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          mem_reg[gi] <= '0;
        end else if (push && (wr_ptr_reg == ptr_w'(gi))) begin
          mem_reg[gi] <= '{data: push_data, row_idx: row_idx_reg,
                           tile_last: (row_idx_reg == last_row)};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      byte_cnt_reg <= '0;
      row_idx_reg  <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      if (push) begin
        byte_cnt_reg <= '0;
        row_idx_reg  <= (row_idx_reg == last_row) ? '0 : row_idx_reg + idx_w'(1);
        wr_ptr_reg   <= wr_ptr_reg + ptr_w'(1);
      end else if (accept) begin
        byte_cnt_reg <= byte_cnt_reg + cnt_w'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + ptr_w'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + fcnt_w'(1);
        2'b01:   count_reg <= count_reg - fcnt_w'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef SYSTOLIC_COLLECTOR_PERF_CNT_EN
  logic [31:0] stall_cnt_reg, row_cnt_reg, tile_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      stall_cnt_reg <= '0;
      row_cnt_reg   <= '0;
      tile_cnt_reg  <= '0;
    end else begin
      if (bus.v_i && en_i && stall && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if (push && (row_cnt_reg != '1)) begin
        row_cnt_reg <= row_cnt_reg + 32'd1;
      end
      if (push && (row_idx_reg == last_row) && (tile_cnt_reg != '1)) begin
        tile_cnt_reg <= tile_cnt_reg + 32'd1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
  assign row_cnt_o   = row_cnt_reg;
  assign tile_cnt_o  = tile_cnt_reg;
`endif
endmodule

// File: tb/tb_systolic_result_collector.sv
// Directed bench for systolic_result_collector: a scoreboard queue of expected rows checked by a
// monitor on every downstream pop, plus direct checks of handshake, latency, flush, freeze and reset.
module tb_systolic_result_collector;
  typedef struct packed {
    logic [63:0] d;
    logic [2:0]  r;
    logic        t;
  } exp_t;

  logic clk, reset, en, flush;
  logic auto_pop, yumi_man;
  logic [3:0] partial;
`ifdef SYSTOLIC_COLLECTOR_PERF_CNT_EN
  logic [31:0] stall_cnt, row_cnt, tile_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int pops_seen = 0;
  int tiles_seen = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [63:0] cur_row;
  int exp_lane, exp_row;

  systolic_result_collector_if #(.width_p(8), .array_width_p(8), .array_height_p(8)) intf ();

  systolic_result_collector #(.width_p(8), .array_width_p(8), .array_height_p(8), .depth_p(4)) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .en_i      (en),
    .flush_i   (flush),
    .bus       (intf.slave),
    .partial_o (partial)
`ifdef SYSTOLIC_COLLECTOR_PERF_CNT_EN
    ,
    .stall_cnt_o (stall_cnt),
    .row_cnt_o   (row_cnt),
    .tile_cnt_o  (tile_cnt)
`endif
  );

  assign intf.yumi_i = auto_pop ? intf.valid_o : yumi_man;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    cur_row  = '0;
    exp_lane = 0;
    exp_row  = 0;
  endtask

  // Record an accepted byte; a completed row becomes an expected scoreboard entry.
  task automatic note_accept(input logic [7:0] b);
    cur_row[exp_lane*8 +: 8] = b;
    exp_lane++;
    if (exp_lane == 8) begin
      exp_q.push_back('{d: cur_row, r: 3'(exp_row), t: (exp_row == 7)});
      exp_lane = 0;
      exp_row  = (exp_row + 1) % 8;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int waits);
    bit done;
    done  = 0;
    waits = 0;
    intf.v_i    = 1'b1;
    intf.data_i = b;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      waits = k + 1;
      if (intf.yumi_o) begin
        done = 1;
        note_accept(b);
      end
      step();
    end
    if (!done) check("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic send_run(input logic [7:0] base, input int n);
    int w;
    for (int i = 0; i < n; i++) send_byte(base + 8'(i), w);
    intf.v_i = 1'b0;
  endtask

  task automatic do_flush();
    intf.v_i = 1'b0;
    flush    = 1'b1;
    clear_model();
    step();
    flush = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && en && !flush && intf.valid_o && intf.yumi_i) begin
      pops_seen++;
      if (intf.tile_last_o) tiles_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_row: got row 0x%0h required no row", intf.data_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("row_data", intf.data_o, mon_e.d);
        check("row_idx", 64'(intf.row_idx_o), 64'(mon_e.r));
        check("row_tile_last", 64'(intf.tile_last_o), 64'(mon_e.t));
      end
    end
  end

  initial begin
    int w, p0;
    clear_model();
    reset = 1'b1; en = 1'b1; flush = 1'b0;
    auto_pop = 1'b0; yumi_man = 1'b1;
    intf.v_i = 1'b1; intf.data_i = 8'h55;

    // Reset state, with v_i and yumi_i asserted to show they are ignored.
    step(); step();
    @(negedge clk);
    check("rst_yumi_o", 64'(intf.yumi_o), 64'(0));
    check("rst_valid_o", 64'(intf.valid_o), 64'(0));
    check("rst_data_o", intf.data_o, 64'(0));
    check("rst_row_idx", 64'(intf.row_idx_o), 64'(0));
    check("rst_tile_last", 64'(intf.tile_last_o), 64'(0));
    check("rst_partial", 64'(partial), 64'(0));
    step();
    reset = 1'b0; intf.v_i = 1'b0; yumi_man = 1'b0;

    // Basic pack: 0x01..0x08 back to back, no pop.
    for (int i = 1; i <= 8; i++) begin
      send_byte(8'(i), w);
      check("basic_yumi_first_try", 64'(w), 64'(1));
      if (i == 7) check("basic_no_bypass", 64'(intf.valid_o), 64'(0));
    end
    intf.v_i = 1'b0;
    check("basic_latency_valid", 64'(intf.valid_o), 64'(1));
    @(negedge clk);
    check("basic_data", intf.data_o, 64'h0807060504030201);
    check("basic_row_idx", 64'(intf.row_idx_o), 64'(0));
    check("basic_tile_last", 64'(intf.tile_last_o), 64'(0));
    check("basic_partial", 64'(partial), 64'(0));
    step();
    yumi_man = 1'b1;
    step();
    yumi_man = 1'b1;
    step();
    yumi_man = 1'b0;
    check("basic_popped_empty", 64'(intf.valid_o), 64'(0));
    check("basic_sb_empty", 64'(exp_q.size()), 64'(0));

    // Tile tagging: 64 bytes with yumi_i tied to valid_o, then one more row.
    do_flush();
    auto_pop = 1'b1;
    p0 = pops_seen;
    tiles_seen = 0;
    send_run(8'h40, 64);
    repeat (4) step();
    check("tile_rows_popped", 64'(pops_seen - p0), 64'(8));
    check("tile_last_count", 64'(tiles_seen), 64'(1));
`ifdef SYSTOLIC_COLLECTOR_PERF_CNT_EN
    check("tile_perf_rows", 64'(row_cnt), 64'(8));
    check("tile_perf_tiles", 64'(tile_cnt), 64'(1));
`endif
    send_run(8'h90, 8);
    repeat (4) step();
    check("tile_wrap_sb_empty", 64'(exp_q.size()), 64'(0));

    // Backpressure: four rows fill the FIFO, lane 7 of row 5 waits for a pop.
    do_flush();
    auto_pop = 1'b0; yumi_man = 1'b0;
    send_run(8'h80, 39);
    intf.v_i = 1'b1; intf.data_i = 8'hA7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_stalled_yumi", 64'(intf.yumi_o), 64'(0));
      check("bp_partial", 64'(partial), 64'(7));
      step();
    end
    yumi_man = 1'b1;
    @(negedge clk);
    check("bp_popthrough_yumi", 64'(intf.yumi_o), 64'(1));
    if (intf.yumi_o) note_accept(8'hA7);
    step();
    yumi_man = 1'b0; intf.v_i = 1'b0;
    check("bp_partial_wrapped", 64'(partial), 64'(0));
`ifdef SYSTOLIC_COLLECTOR_PERF_CNT_EN
    check("bp_perf_stall", 64'(stall_cnt), 64'(3));
    check("bp_perf_rows", 64'(row_cnt), 64'(5));
`endif
    yumi_man = 1'b1;
    repeat (4) step();
    yumi_man = 1'b0;
    check("bp_count_was_4", 64'(intf.valid_o), 64'(0));
    check("bp_sb_empty", 64'(exp_q.size()), 64'(0));

    // Flush mid-row: two rows buffered plus three bytes, flush with a byte on offer.
    do_flush();
    send_run(8'hA0, 19);
    intf.v_i = 1'b1; intf.data_i = 8'hEE; flush = 1'b1;
    clear_model();
    @(negedge clk);
    check("flush_yumi", 64'(intf.yumi_o), 64'(0));
    step();
    flush = 1'b0; intf.v_i = 1'b0;
    @(negedge clk);
    check("flush_valid", 64'(intf.valid_o), 64'(0));
    check("flush_partial", 64'(partial), 64'(0));
    step();
    auto_pop = 1'b1;
    send_run(8'hB0, 8);
    repeat (4) step();
    check("flush_sb_empty", 64'(exp_q.size()), 64'(0));

    // Enable freeze with v_i and yumi_i both high.
    do_flush();
    auto_pop = 1'b0; yumi_man = 1'b0;
    send_run(8'hC0, 11);
    intf.v_i = 1'b1; intf.data_i = 8'hCB; en = 1'b0; yumi_man = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("freeze_yumi", 64'(intf.yumi_o), 64'(0));
      check("freeze_partial", 64'(partial), 64'(3));
      check("freeze_valid", 64'(intf.valid_o), 64'(1));
      check("freeze_head", intf.data_o, 64'hC7C6C5C4C3C2C1C0);
      step();
    end
    en = 1'b1; yumi_man = 1'b0; auto_pop = 1'b1;
    send_run(8'hCB, 5);
    repeat (4) step();
    check("freeze_sb_empty", 64'(exp_q.size()), 64'(0));

    // Reset mid-tile: three rows plus five bytes, then reset with a byte on offer.
    do_flush();
    auto_pop = 1'b0; yumi_man = 1'b0;
    send_run(8'hE0, 29);
`ifdef SYSTOLIC_COLLECTOR_PERF_CNT_EN
    check("rst_mid_perf_rows", 64'(row_cnt), 64'(3));
    check("rst_mid_perf_tiles", 64'(tile_cnt), 64'(0));
`endif
    reset = 1'b1; intf.v_i = 1'b1; intf.data_i = 8'h77;
    clear_model();
    step();
    @(negedge clk);
    check("rst_mid_yumi", 64'(intf.yumi_o), 64'(0));
    check("rst_mid_valid", 64'(intf.valid_o), 64'(0));
    check("rst_mid_data", intf.data_o, 64'(0));
    check("rst_mid_row_idx", 64'(intf.row_idx_o), 64'(0));
    check("rst_mid_tile_last", 64'(intf.tile_last_o), 64'(0));
    check("rst_mid_partial", 64'(partial), 64'(0));
`ifdef SYSTOLIC_COLLECTOR_PERF_CNT_EN
    check("rst_mid_perf_stall", 64'(stall_cnt), 64'(0));
    check("rst_mid_perf_rows0", 64'(row_cnt), 64'(0));
    check("rst_mid_perf_tiles0", 64'(tile_cnt), 64'(0));
`endif
    step();
    reset = 1'b0; intf.v_i = 1'b0; auto_pop = 1'b1;
    send_byte(8'hD0, w);
    intf.v_i = 1'b0;
    check("rst_first_lane", 64'(partial), 64'(1));
    send_run(8'hD1, 7);
    repeat (4) step();
    check("rst_sb_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/systolic_result_collector.md
Name: systolic_result_collector

Overview:
Output-side consumer for the systolic_array byte stream. It accepts result bytes with the valid/yumi handshake: the array drives valid and data, and this block drives yumi. It packs array_width_p bytes into one row word and tags each row with its index within the tile and an end-of-tile flag. Completed rows are buffered in a small FIFO and presented downstream on a second valid/yumi interface.

Parameters:
width_p, 8, bits per result element
array_width_p, 8, elements per packed row
array_height_p, 8, rows per tile (tile_last tagging)
depth_p, 4, row FIFO depth in entries; power of 2, ≥2

Ports:
clk_i  in  1  clock; all state updates on posedge
reset_i  in  1  synchronous, active-high reset
en_i  in  1  global enable; low freezes all state
flush_i  in  1  synchronous clear of assembler, FIFO and row counter
v_i  in  1  result byte valid (driven by systolic_array valid_o)
data_i  in  width_p  result byte (driven by systolic_array data_o)
yumi_o  out  1  byte consumed this cycle (drives systolic_array yumi_i)
valid_o  out  1  packed row available at FIFO head
data_o  out  width_p*array_width_p  packed row; byte k at bits [k*width_p +: width_p]
row_idx_o  out  $clog2(array_height_p)  tile row index of head row
tile_last_o  out  1  head row is row array_height_p-1 of its tile
yumi_i  in  1  downstream pops head row; legal only while valid_o=1
partial_o  out  $clog2(array_width_p+1)  bytes held in assembler

Behaviour:
- Priority is reset_i > flush_i > en_i=0 > normal operation.
- Reset: yumi_o=0, valid_o=0, data_o=0, row_idx_o=0, tile_last_o=0, partial_o=0. FIFO storage is cleared to 0.
- pop = valid_o & yumi_i & en_i & !flush_i. If yumi_i is asserted while valid_o=0, it is ignored; there is no state change and no error.
- yumi_o = v_i & en_i & !flush_i & !stall.
- stall = (byte_cnt==array_width_p-1) & fifo_full & !pop. Same-cycle pop-through is allowed, so yumi_o combinationally depends on yumi_i.
- Byte accept: data_i is written to lane byte_cnt and byte_cnt increments. On lane array_width_p-1, the row is pushed into the FIFO with the current row_idx, and byte_cnt wraps to 0.
- row_idx increments on each push and wraps to 0 after array_height_p-1. tile_last=1 is stored with the pushed row when the pushed row_idx is array_height_p-1.
- Latency: if the last byte of a row is accepted in cycle N, valid_o=1 in cycle N+1 (FIFO previously empty). No bypass path.
- FIFO: depth_p entries, with circular read and write pointers plus a count. Simultaneous push and pop when full or empty is legal, and the count is unchanged when full. data_o, row_idx_o and tile_last_o show the head entry, and they hold stable while valid_o=1 and no pop occurs.
- flush_i=1: yumi_o=0 in that cycle. The next cycle has byte_cnt=0, row_idx=0, the FIFO empty and valid_o=0. Any partial row is discarded. A flush held over multiple cycles keeps everything cleared.
- en_i=0: yumi_o=0, with no push, no pop and no counter change. valid_o and the head outputs keep showing the current FIFO state.
- Reset asserted mid-row or mid-tile discards all data. The next byte after reset goes to lane 0 of row 0.
- partial_o equals byte_cnt.

Optional Feature:
SYSTOLIC_COLLECTOR_PERF_CNT_EN
- Defined: adds three 32-bit outputs, each cleared by reset_i and flush_i and each saturating at 2^32-1.
  - stall_cnt_o counts cycles with v_i & en_i & stall.
  - row_cnt_o counts FIFO pushes.
  - tile_cnt_o counts pushes with tile_last set.
- Undefined: these ports and counters are absent, and the remaining behaviour is identical.

Test Plan:
- Basic pack: stream bytes 0x01..0x08 with v_i held high and yumi_i=0. Expected: yumi_o=1 for 8 cycles and valid_o=1 one cycle after the last byte. data_o=0x0807060504030201, row_idx_o=0, tile_last_o=0.
- Tile tagging: stream 64 bytes with yumi_i=valid_o. Expected: 8 rows popped with row_idx_o 0..7, tile_last_o=1 only on row 7. The 65th byte lands in row_idx 0.
- Backpressure: yumi_i=0 and 40 bytes offered (depth_p=4). Expected: 4 rows buffered, then yumi_o=0 while lane 7 of row 5 waits. Asserting yumi_i for one cycle accepts that byte in the same cycle (pop-through), and the count stays 4.
- Flush mid-row: accept 3 bytes, 2 rows buffered, pulse flush_i. Expected next cycle: valid_o=0, partial_o=0. The following 8 bytes form row_idx 0.
- Enable freeze: drop en_i for 5 cycles with v_i=1 and yumi_i=1. Expected: yumi_o=0, no pop, partial_o and the head row unchanged. On re-enable, normal operation resumes with no lost or duplicated bytes.
- Reset mid-tile: assert reset_i after 3 rows plus 5 bytes. Expected: all outputs at reset values the next cycle. With SYSTOLIC_COLLECTOR_PERF_CNT_EN, counters read 0. Earlier in the same run, row_cnt_o=3 before reset and stall_cnt_o matches the counted stall cycles.
